// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 register-file write-back path.
//   XLEN       architectural data width
//   REG_AW     register index width
//   XZR_IDX    index of the zero register (writes to it are discarded)
//   wb_entry_t one pending write-back: destination index plus data
//   is_xzr()   true when an index names the zero register
// -----------------------------------------------------------------------------
package legv8_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic is_xzr(input logic [REG_AW-1:0] idx);
        return (idx == XZR_IDX);
    endfunction

endpackage

// File: rtl/reg_wb_match.sv
// -----------------------------------------------------------------------------
// reg_wb_match
// Youngest-first associative search over the write-back queue storage.
// Ports:
//   entries  in   DEPTH queue slots (physical order)
//   valid    in   per-slot occupancy mask
//   head     in   slot index of the oldest entry
//   lookup   in   register index being looked up
//   hit      out  some occupied slot targets lookup
//   data     out  data of the youngest occupied slot targeting lookup
// A lookup of XZR never hits.
// -----------------------------------------------------------------------------
module reg_wb_match
    import legv8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  wb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PW-1:0]      head,
    input  logic [REG_AW-1:0]  lookup,
    output logic               hit,
    output logic [XLEN-1:0]    data
);

    // Walk oldest -> youngest; later matches overwrite earlier ones so the
    // youngest matching entry supplies the data.
    always_comb begin
        logic [PW-1:0] idx;
        logic          m;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        m    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx  = head + PW'(k);
            m    = valid[idx] && (entries[idx].rd == lookup) && !is_xzr(lookup);
            hit  = hit | m;
            data = m ? entries[idx].data : data;
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
// In-order write-back queue feeding the single write port of the 32x64 LEGv8
// register file. Two producers (memory, ALU) enqueue; one entry drains per
// cycle when the write port is available. Writes to XZR are accepted and
// dropped. Optional bypass lookup exposes pending data to decode.
//
// Configuration macro: WB_BYPASS_EN (defined -> bypass match logic present;
// undefined -> BYP_HITn/BYP_DATAn tied to zero, bypass inputs ignored).
//
// Ports:
//   CLK, RST_N                      clock (rising edge), async active-low reset
//   MEM_VALID/MEM_RD/MEM_DATA       memory result in; MEM_READY accept
//   ALU_VALID/ALU_RD/ALU_DATA       ALU result in;    ALU_READY accept
//   DRAIN_EN                        register-file write port available
//   REG_WRITE/WR_REG/WR_DATA        register-file write port (head entry)
//   BYP_REG1/2 -> BYP_HIT1/2, BYP_DATA1/2   bypass lookup
//   COUNT, FULL, EMPTY              occupancy status
// -----------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int AW    = 5
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       MEM_VALID,
    input  logic [AW-1:0]              MEM_RD,
    input  logic [XLEN-1:0]            MEM_DATA,
    output logic                       MEM_READY,
    input  logic                       ALU_VALID,
    input  logic [AW-1:0]              ALU_RD,
    input  logic [XLEN-1:0]            ALU_DATA,
    output logic                       ALU_READY,
    input  logic                       DRAIN_EN,
    output logic                       REG_WRITE,
    output logic [AW-1:0]              WR_REG,
    output logic [XLEN-1:0]            WR_DATA,
    input  logic [AW-1:0]              BYP_REG1,
    input  logic [AW-1:0]              BYP_REG2,
    output logic                       BYP_HIT1,
    output logic                       BYP_HIT2,
    output logic [XLEN-1:0]            BYP_DATA1,
    output logic [XLEN-1:0]            BYP_DATA2,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       FULL,
    output logic                       EMPTY
);

    import legv8_pkg::wb_entry_t;
    import legv8_pkg::is_xzr;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         entries_r [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;

    logic [CW-1:0]     free_s;
    logic              mem_keep_s;
    logic              alu_keep_s;
    logic              mem_push_s;
    logic              alu_push_s;
    logic              pop_s;
    logic [PW-1:0]     alu_slot_s;
    logic [DEPTH-1:0]  valid_s;

    // Slot i is occupied when its distance from head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        assign valid_s[i] = ({1'b0, PW'(i) - head_r} < count_r);
    end

    // Handshake and drain control. Free space comes from the registered count
    // only, so a pop in the same cycle never frees room for a push.
    always_comb begin
        free_s     = CW'(DEPTH) - count_r;
        mem_keep_s = MEM_VALID & !is_xzr(MEM_RD);
        alu_keep_s = ALU_VALID & !is_xzr(ALU_RD);

        if (is_xzr(MEM_RD)) begin
            MEM_READY = 1'b1;
        end else begin
            MEM_READY = (free_s >= CW'(1));
        end

        // A storable MEM result claims the first free slot ahead of the ALU.
        if (is_xzr(ALU_RD)) begin
            ALU_READY = 1'b1;
        end else if (mem_keep_s) begin
            ALU_READY = (free_s >= CW'(2));
        end else begin
            ALU_READY = (free_s >= CW'(1));
        end

        mem_push_s = mem_keep_s & MEM_READY;
        alu_push_s = alu_keep_s & ALU_READY;
        alu_slot_s = tail_r + PW'(mem_push_s);

        EMPTY      = (count_r == CW'(0));
        FULL       = (count_r == CW'(DEPTH));
        pop_s      = !EMPTY & DRAIN_EN;
        REG_WRITE  = pop_s;
        WR_REG     = entries_r[head_r].rd;
        WR_DATA    = entries_r[head_r].data;
        COUNT      = count_r;
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            if (mem_push_s) begin
                entries_r[tail_r] <= '{rd: MEM_RD, data: MEM_DATA};
            end
            if (alu_push_s) begin
                entries_r[alu_slot_s] <= '{rd: ALU_RD, data: ALU_DATA};
            end
            head_r  <= head_r + PW'(pop_s);
            tail_r  <= tail_r + PW'(mem_push_s) + PW'(alu_push_s);
            count_r <= count_r + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
        end
    end

`ifdef WB_BYPASS_EN
    // Only registered entries are searched; this cycle's pushes are not.
    reg_wb_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_match1 (
        .entries (entries_r),
        .valid   (valid_s),
        .head    (head_r),
        .lookup  (BYP_REG1),
        .hit     (BYP_HIT1),
        .data    (BYP_DATA1)
    );

    reg_wb_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_match2 (
        .entries (entries_r),
        .valid   (valid_s),
        .head    (head_r),
        .lookup  (BYP_REG2),
        .hit     (BYP_HIT2),
        .data    (BYP_DATA2)
    );
`else
    logic unused_byp_s;

    assign BYP_HIT1     = 1'b0;
    assign BYP_HIT2     = 1'b0;
    assign BYP_DATA1    = '0;
    assign BYP_DATA2    = '0;
    assign unused_byp_s = ^{BYP_REG1, BYP_REG2, valid_s};
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_queue
// Directed bench for reg_wb_queue. A small occupancy model predicts READY,
// COUNT/FULL/EMPTY and REG_WRITE; accepted writes go into a scoreboard queue
// and are popped and compared whenever the queue drains a write.
// -----------------------------------------------------------------------------
module tb_reg_wb_queue;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_VALID;
    logic [4:0]  MEM_RD;
    logic [63:0] MEM_DATA;
    logic        MEM_READY;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [63:0] ALU_DATA;
    logic        ALU_READY;
    logic        DRAIN_EN;
    logic        REG_WRITE;
    logic [4:0]  WR_REG;
    logic [63:0] WR_DATA;
    logic [4:0]  BYP_REG1;
    logic [4:0]  BYP_REG2;
    logic        BYP_HIT1;
    logic        BYP_HIT2;
    logic [63:0] BYP_DATA1;
    logic [63:0] BYP_DATA2;
    logic [2:0]  COUNT;
    logic        FULL;
    logic        EMPTY;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   model_count = 0;
    int   n_cmp       = 0;
    int   n_fail      = 0;

    reg_wb_queue #(.DEPTH(4), .XLEN(64), .AW(5)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MEM_VALID (MEM_VALID),
        .MEM_RD    (MEM_RD),
        .MEM_DATA  (MEM_DATA),
        .MEM_READY (MEM_READY),
        .ALU_VALID (ALU_VALID),
        .ALU_RD    (ALU_RD),
        .ALU_DATA  (ALU_DATA),
        .ALU_READY (ALU_READY),
        .DRAIN_EN  (DRAIN_EN),
        .REG_WRITE (REG_WRITE),
        .WR_REG    (WR_REG),
        .WR_DATA   (WR_DATA),
        .BYP_REG1  (BYP_REG1),
        .BYP_REG2  (BYP_REG2),
        .BYP_HIT1  (BYP_HIT1),
        .BYP_HIT2  (BYP_HIT2),
        .BYP_DATA1 (BYP_DATA1),
        .BYP_DATA2 (BYP_DATA2),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic set(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic dr);
        MEM_VALID = mv;
        MEM_RD    = mrd;
        MEM_DATA  = md;
        ALU_VALID = av;
        ALU_RD    = ard;
        ALU_DATA  = ad;
        DRAIN_EN  = dr;
    endtask

    // One clock cycle: check this cycle's outputs against the model, update
    // the model/scoreboard, then advance to the next falling edge.
    task automatic step();
        int   free;
        logic mk;
        logic emr;
        logic ear;
        logic ewr;
        exp_t e;
        #1;
        free = 4 - model_count;
        mk   = MEM_VALID && (MEM_RD != 5'd31);
        emr  = (MEM_RD == 5'd31) ? 1'b1 : (free >= 1);
        ear  = (ALU_RD == 5'd31) ? 1'b1 : (mk ? (free >= 2) : (free >= 1));
        ewr  = (model_count > 0) && DRAIN_EN;
        chk("mem_ready", {63'd0, MEM_READY}, {63'd0, emr});
        chk("alu_ready", {63'd0, ALU_READY}, {63'd0, ear});
        chk("count", {61'd0, COUNT}, 64'(model_count));
        chk("empty", {63'd0, EMPTY}, {63'd0, model_count == 0});
        chk("full", {63'd0, FULL}, {63'd0, model_count == 4});
        chk("reg_write", {63'd0, REG_WRITE}, {63'd0, ewr});
        if (ewr && sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_reg", {59'd0, WR_REG}, {59'd0, e.rd});
            chk("wr_data", WR_DATA, e.data);
            model_count--;
        end
        if (mk && emr) begin
            sb.push_back('{rd: MEM_RD, data: MEM_DATA});
            model_count++;
        end
        if (ALU_VALID && (ALU_RD != 5'd31) && ear) begin
            sb.push_back('{rd: ALU_RD, data: ALU_DATA});
            model_count++;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic        exp_hit;
        logic [63:0] exp_bd;

        RST_N    = 1'b0;
        BYP_REG1 = 5'd0;
        BYP_REG2 = 5'd0;
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        #1;
        chk("rst_count", {61'd0, COUNT}, 64'd0);
        chk("rst_empty", {63'd0, EMPTY}, 64'd1);
        chk("rst_full", {63'd0, FULL}, 64'd0);
        chk("rst_reg_write", {63'd0, REG_WRITE}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: single ALU write, drained the next cycle
        set(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'hAA, 1'b1);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        step();
        step();

        // 2: simultaneous MEM and ALU to the same register, MEM first
        set(1'b1, 5'd5, 64'd1, 1'b1, 5'd5, 64'd2, 1'b1);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        repeat (3) step();

        // 3: fill to FULL with drain off, then drain across the pointer wrap
        set(1'b1, 5'd10, 64'h100, 1'b1, 5'd11, 64'h101, 1'b0);
        step();
        set(1'b1, 5'd12, 64'h102, 1'b1, 5'd13, 64'h103, 1'b0);
        step();
        set(1'b1, 5'd14, 64'h104, 1'b1, 5'd15, 64'h105, 1'b0);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        repeat (5) step();

        // 4: COUNT=3, both producers valid -> only MEM fits; ALU next cycle
        set(1'b1, 5'd16, 64'h200, 1'b1, 5'd17, 64'h201, 1'b0);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b1, 5'd18, 64'h202, 1'b0);
        step();
        set(1'b1, 5'd20, 64'h203, 1'b1, 5'd21, 64'h204, 1'b1);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b1, 5'd21, 64'h204, 1'b1);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        repeat (4) step();

        // 5: XZR discard, including XZR MEM not reserving a slot and XZR when full
        set(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFF, 1'b1);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        step();
        set(1'b1, 5'd1, 64'h301, 1'b1, 5'd2, 64'h302, 1'b0);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h303, 1'b0);
        step();
        set(1'b1, 5'd31, 64'h3FF, 1'b1, 5'd9, 64'h309, 1'b0);
        step();
        set(1'b1, 5'd31, 64'h3FE, 1'b1, 5'd31, 64'h3FD, 1'b0);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
        repeat (5) step();

        // 6: bypass lookup of two pending writes to X7, then reset mid-drain
        set(1'b1, 5'd7, 64'h10, 1'b1, 5'd7, 64'h20, 1'b0);
        step();
        set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        BYP_REG1 = 5'd7;
        BYP_REG2 = 5'd31;
        #1;
`ifdef WB_BYPASS_EN
        exp_hit = 1'b1;
        exp_bd  = 64'h20;
`else
        exp_hit = 1'b0;
        exp_bd  = 64'd0;
`endif
        chk("byp_hit1", {63'd0, BYP_HIT1}, {63'd0, exp_hit});
        chk("byp_data1", BYP_DATA1, exp_bd);
        chk("byp_hit2_xzr", {63'd0, BYP_HIT2}, 64'd0);
        BYP_REG2 = 5'd8;
        #1;
        chk("byp_hit2_miss", {63'd0, BYP_HIT2}, 64'd0);
        chk("byp_data2_miss", BYP_DATA2, 64'd0);
        step();
        DRAIN_EN = 1'b1;
        #1;
        chk("pre_rst_reg_write", {63'd0, REG_WRITE}, 64'd1);
        chk("pre_rst_wr_data", WR_DATA, 64'h10);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_reg_write", {63'd0, REG_WRITE}, 64'd0);
        chk("mid_rst_count", {61'd0, COUNT}, 64'd0);
        chk("mid_rst_empty", {63'd0, EMPTY}, 64'd1);
        model_count = 0;
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
